// File: rtl/darkbus_pkg.sv
// Shared types and constants for the darkbus fetch/memory-stage arbiter.
package darkbus_pkg;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_BUSY = 2'd1;
    localparam arb_state_t ARB_RESP = 2'd2;

    typedef enum logic {
        OWN_FE = 1'b0,
        OWN_ME = 1'b1
    } owner_t;

    localparam int DARKBUS_AW = 32;
    localparam int DARKBUS_DW = 32;

    // Request at the default bus geometry; the arbiter declares the same layout at its own widths.
    typedef struct packed {
        logic                      rw;
        logic [DARKBUS_DW/8-1:0]   be;
        logic [DARKBUS_AW-1:0]     addr;
        logic [DARKBUS_DW-1:0]     wdata;
    } bus_req_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/darkbus_arb_pick.sv
// Combinational winner select between the fetch and memory-stage requesters.
module darkbus_arb_pick
    import darkbus_pkg::*;
#(
    parameter int PRIORITY = 0
) (
    input  logic   fe_en_i,
    input  logic   me_en_i,
    input  owner_t last_i,
    output logic   grant_o,
    output owner_t owner_o
);

    always_comb begin
        grant_o = fe_en_i | me_en_i;
        owner_o = OWN_FE;
        if (fe_en_i && me_en_i) begin
            // Round-robin hands a tie to whoever did not own the bus last.
            if (PRIORITY == 0) begin
                owner_o = OWN_ME;
            end else begin
                owner_o = (last_i == OWN_ME) ? OWN_FE : OWN_ME;
            end
        end else if (me_en_i) begin
            owner_o = OWN_ME;
        end
    end

endmodule

// File: rtl/darkbus_arbiter.sv
// Registered arbiter sharing the core-side darkbus port between fetch and memory stages,
// with grant locking, fixed/round-robin tie break and a response timeout.
module darkbus_arbiter
    import darkbus_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int PRIORITY = 0,
    parameter int TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            res,
    input  logic            fe_en,
    input  logic            fe_rw,
    input  logic [DW/8-1:0] fe_be,
    input  logic [AW-1:0]   fe_addr,
    input  logic [DW-1:0]   fe_wdata,
    output logic [DW-1:0]   fe_rdata,
    output logic            fe_valid,
    output logic            fe_err,
    input  logic            me_en,
    input  logic            me_rw,
    input  logic [DW/8-1:0] me_be,
    input  logic [AW-1:0]   me_addr,
    input  logic [DW-1:0]   me_wdata,
    output logic [DW-1:0]   me_rdata,
    output logic            me_valid,
    output logic            me_err,
    output logic            tgt_en,
    output logic            tgt_rw,
    output logic [DW/8-1:0] tgt_be,
    output logic [AW-1:0]   tgt_addr,
    output logic [DW-1:0]   tgt_wdata,
    input  logic [DW-1:0]   tgt_rdata,
    input  logic            tgt_valid,
    output logic            busy,
    output logic            owner,
    output logic [7:0]      to_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic            rw;
        logic [DW/8-1:0] be;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } req_t;

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d;
    req_t          req_q, req_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [7:0]    to_count_q, to_count_d;

    logic   pick_grant;
    owner_t pick_owner;
    logic   expire;

    darkbus_arb_pick #(.PRIORITY(PRIORITY)) u_pick (
        .fe_en_i (fe_en),
        .me_en_i (me_en),
        .last_i  (owner_q),
        .grant_o (pick_grant),
        .owner_o (pick_owner)
    );

    assign expire = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        req_d      = req_q;
        timer_d    = timer_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        to_count_d = to_count_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_grant) begin
                    owner_d = pick_owner;
                    req_d   = (pick_owner == OWN_ME) ? req_t'{me_rw, me_be, me_addr, me_wdata}
                                                     : req_t'{fe_rw, fe_be, fe_addr, fe_wdata};
                    timer_d = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                timer_d = timer_q + 1'b1;
                // A completion arriving on the expiry cycle still counts as a good response.
                if (tgt_valid) begin
                    rdata_d = req_q.rw ? '0 : tgt_rdata;
                    err_d   = 1'b0;
                    state_d = ARB_RESP;
                end else if (expire) begin
                    rdata_d    = '0;
                    err_d      = 1'b1;
                    to_count_d = sat_inc8(to_count_q);
                    state_d    = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_ME;
            req_q      <= '0;
            timer_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            to_count_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            timer_q    <= timer_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            to_count_q <= to_count_d;
        end
    end

    assign tgt_en    = (state_q == ARB_BUSY);
    assign tgt_rw    = req_q.rw;
    assign tgt_be    = req_q.be;
    assign tgt_addr  = req_q.addr;
    assign tgt_wdata = req_q.wdata;

    assign fe_valid  = (state_q == ARB_RESP) && (owner_q == OWN_FE);
    assign me_valid  = (state_q == ARB_RESP) && (owner_q == OWN_ME);
    assign fe_err    = fe_valid & err_q;
    assign me_err    = me_valid & err_q;
    assign fe_rdata  = rdata_q;
    assign me_rdata  = rdata_q;

    assign busy      = (state_q != ARB_IDLE);
    assign owner     = owner_q;
    assign to_count  = to_count_q;

endmodule
